// File: rtl/multi_pulse_sequencer.sv
// multi_pulse_sequencer: RF shot sequencer (pulse/gap pairs, receive window, repeats)
// with rising-edge start, level abort and fully registered outputs.
module multi_pulse_sequencer #(
   parameter int NUM_PULSES = 4,
   parameter int TW = 32,
   parameter int PW = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     RF_signal_valid,
   input  logic [NUM_PULSES*TW-1:0] pulse_len,
   input  logic [NUM_PULSES*TW-1:0] gap_len,
   input  logic [NUM_PULSES*PW-1:0] pulse_phase,
   input  logic [TW-1:0]            rec_len,
   input  logic [15:0]              rep_count,
   input  logic [TW-1:0]            rep_delay,
   output logic [PW-1:0]            TX_active_phase,
   output logic                     amp_enable,
   output logic                     ADC_enable,
   output logic                     busy,
   output logic                     shot_done,
   output logic                     seq_done
);
   localparam int SEGS = 2*NUM_PULSES+1;
   localparam int SW = $clog2(SEGS+1);
   localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_PULSE = 3'd2,
                          S_GAP = 3'd3, S_REC = 3'd4, S_REPDLY = 3'd5;
   logic [2:0]                r_state, w_nstate;
   logic [TW-1:0]             r_cnt, w_ncnt;
   logic [SW-1:0]             r_seg, w_nseg, w_first, w_next, w_tgt;
   logic [15:0]               r_shot, w_nshot, w_reps;
   logic                      r_empty, w_nempty, r_prev, w_sd, w_qd, w_begin, w_end, w_last, w_trig;
   logic [NUM_PULSES*TW-1:0]  r_plen, r_glen;
   logic [NUM_PULSES*PW-1:0]  r_ph;
   logic [TW-1:0]             r_rec, r_rdly;
   logic [15:0]               r_rep;
   logic [SEGS-1:0][TW-1:0]   w_len;
   logic [SW-2:0]             w_pidx;
   logic [PW-1:0]             r_txph;
   logic                      r_amp, r_adc, r_busy, r_sd, r_qd;
   // Segment s: even = pulse s/2, odd = gap s/2, last = receive window.
   function automatic logic [SW-1:0] first_from(input logic [SEGS-1:0][TW-1:0] len,
                                                input logic [SW-1:0] start);
      first_from = SW'(SEGS);
      for (int k = SEGS-1; k >= 0; k--)
         if (SW'(k) >= start && len[k] != '0) first_from = SW'(k);
   endfunction
   function automatic logic [2:0] seg_state(input logic [SW-1:0] s);
      seg_state = (s == SW'(SEGS-1)) ? S_REC : s[0] ? S_GAP : S_PULSE;
   endfunction
   always_comb begin
      for (int i = 0; i < NUM_PULSES; i++) begin
         w_len[2*i]   = r_plen[i*TW +: TW];
         w_len[2*i+1] = r_glen[i*TW +: TW];
      end
      w_len[SEGS-1] = r_rec;
   end
   assign w_first = first_from(w_len, '0);
   assign w_next  = first_from(w_len, r_seg + SW'(1));
   assign w_reps  = (r_rep == '0) ? 16'd1 : r_rep;
   assign w_last  = (r_shot == w_reps - 16'd1);
   assign w_trig  = (r_state == S_IDLE) && RF_signal_valid && !r_prev;
   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt - 1'b1;
      w_nseg   = r_seg;
      w_nshot  = r_shot;
      w_nempty = r_empty;
      w_sd     = 1'b0;
      w_qd     = 1'b0;
      w_tgt    = SW'(SEGS);
      w_begin  = 1'b0;
      w_end    = 1'b0;
      if (r_state == S_IDLE) begin
         w_ncnt = '0;
         if (w_trig) begin
            w_nstate = S_LOAD;
            w_nshot  = '0;
         end
      end else if (!RF_signal_valid) begin
         w_nstate = S_IDLE;
         w_ncnt   = '0;
      end else if (r_state == S_LOAD) begin
         w_begin = 1'b1;
      end else if (r_cnt == TW'(1)) begin
         if (r_state == S_REPDLY) begin
            w_end   = r_empty;
            w_begin = !r_empty;
         end else if (w_next != SW'(SEGS)) begin
            w_tgt = w_next;
         end else begin
            w_end = 1'b1;
         end
      end
      if (w_end) begin
         w_sd = 1'b1;
         if (w_last) begin
            w_nstate = S_IDLE;
            w_ncnt   = '0;
            w_qd     = 1'b1;
         end else begin
            w_nshot = r_shot + 16'd1;
            if (r_rdly != '0) begin
               w_nstate = S_REPDLY;
               w_ncnt   = r_rdly;
               w_nempty = 1'b0;
            end else begin
               w_begin = 1'b1;
            end
         end
      end
      // A shot with no non-zero segment still occupies one dead cycle.
      if (w_begin) begin
         if (w_first != SW'(SEGS)) begin
            w_tgt = w_first;
         end else begin
            w_nstate = S_REPDLY;
            w_ncnt   = TW'(1);
            w_nempty = 1'b1;
         end
      end
      if (w_tgt != SW'(SEGS)) begin
         w_nseg   = w_tgt;
         w_ncnt   = w_len[w_tgt];
         w_nstate = seg_state(w_tgt);
      end
   end
   assign w_pidx = w_nseg[SW-1:1];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_seg   <= '0;
         r_shot  <= '0;
         r_empty <= 1'b0;
         r_prev  <= 1'b0;
         r_plen  <= '0;
         r_glen  <= '0;
         r_ph    <= '0;
         r_rec   <= '0;
         r_rep   <= '0;
         r_rdly  <= '0;
         r_txph  <= '0;
         r_amp   <= 1'b0;
         r_adc   <= 1'b0;
         r_busy  <= 1'b0;
         r_sd    <= 1'b0;
         r_qd    <= 1'b0;
      end else begin
         r_prev  <= RF_signal_valid;
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_seg   <= w_nseg;
         r_shot  <= w_nshot;
         r_empty <= w_nempty;
         r_amp   <= (w_nstate == S_PULSE);
         r_txph  <= (w_nstate == S_PULSE) ? r_ph[w_pidx*PW +: PW] : '0;
         r_adc   <= (w_nstate == S_REC);
         r_busy  <= (w_nstate != S_IDLE);
         r_sd    <= w_sd;
         r_qd    <= w_qd;
         if (w_trig) begin
            r_plen <= pulse_len;
            r_glen <= gap_len;
            r_ph   <= pulse_phase;
            r_rec  <= rec_len;
            r_rep  <= rep_count;
            r_rdly <= rep_delay;
         end
      end
   end
   assign TX_active_phase = r_txph;
   assign amp_enable      = r_amp;
   assign ADC_enable      = r_adc;
   assign busy            = r_busy;
   assign shot_done       = r_sd;
   assign seq_done        = r_qd;
endmodule

// File: tb/tb_multi_pulse_sequencer.sv
// tb_multi_pulse_sequencer: scoreboard bench; the expected per-cycle output vector
// {busy, amp, adc, phase, shot_done, seq_done} is queued when a sequence is started.
module tb_multi_pulse_sequencer;
   localparam int N = 3;
   localparam int TW = 32;
   localparam int PW = 2;
   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            v = 1'b0;
   logic [N*TW-1:0] pulse_len = '0, gap_len = '0;
   logic [N*PW-1:0] pulse_phase = '0;
   logic [TW-1:0]   rec_len = '0, rep_delay = '0;
   logic [15:0]     rep_count = '0;
   logic [PW-1:0]   tx_phase;
   logic            amp, adc, busy, sd, qd;
   logic [6:0]      obs, exp_v;
   logic [6:0]      sb[$];
   int              pl[N], gl[N], rec, reps, rdly;
   logic [PW-1:0]   ph[N];
   int              vectors = 0, errors = 0, cyc;
   multi_pulse_sequencer #(.NUM_PULSES(N), .TW(TW), .PW(PW)) dut (
      .clk(clk), .rst_n(rst_n), .RF_signal_valid(v),
      .pulse_len(pulse_len), .gap_len(gap_len), .pulse_phase(pulse_phase),
      .rec_len(rec_len), .rep_count(rep_count), .rep_delay(rep_delay),
      .TX_active_phase(tx_phase), .amp_enable(amp), .ADC_enable(adc),
      .busy(busy), .shot_done(sd), .seq_done(qd)
   );
   always #5 clk = ~clk;
   assign obs = {busy, amp, adc, tx_phase, sd, qd};
   task automatic set_cfg(input int p0, p1, p2, g0, g1, g2, r, rc, rd);
      pl[0] = p0; pl[1] = p1; pl[2] = p2;
      gl[0] = g0; gl[1] = g1; gl[2] = g2;
      ph[0] = 2'd1; ph[1] = 2'd2; ph[2] = 2'd3;
      rec = r; reps = rc; rdly = rd;
      for (int i = 0; i < N; i++) begin
         pulse_len[i*TW +: TW]   = pl[i];
         gap_len[i*TW +: TW]     = gl[i];
         pulse_phase[i*PW +: PW] = ph[i];
      end
      rec_len = rec; rep_count = 16'(reps); rep_delay = rdly;
   endtask
   // Expected timeline, LOAD cycle first, then three idle cycles with the run level held high.
   task automatic expand();
      logic pend;
      int   nr;
      pend = 1'b0;
      nr = (reps == 0) ? 1 : reps;
      sb.delete();
      sb.push_back(7'b1000000);
      for (int s = 0; s < nr; s++) begin
         int n;
         n = 0;
         for (int i = 0; i < N; i++) begin
            for (int c = 0; c < pl[i]; c++) begin sb.push_back({3'b110, ph[i], pend, 1'b0}); pend = 1'b0; n++; end
            for (int c = 0; c < gl[i]; c++) begin sb.push_back({5'b10000, pend, 1'b0}); pend = 1'b0; n++; end
         end
         for (int c = 0; c < rec; c++) begin sb.push_back({5'b10100, pend, 1'b0}); pend = 1'b0; n++; end
         if (n == 0) begin sb.push_back({5'b10000, pend, 1'b0}); pend = 1'b0; end
         if (s == nr-1) sb.push_back(7'b0000011);
         else if (rdly > 0) begin
            sb.push_back(7'b1000010);
            for (int c = 1; c < rdly; c++) sb.push_back(7'b1000000);
         end else pend = 1'b1;
      end
      repeat (3) sb.push_back(7'b0000000);
   endtask
   task automatic start_seq();
      v = 1'b0;
      @(negedge clk);
      expand();
      v = 1'b1;
      cyc = 0;
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (obs !== 7'b0) begin errors++; $display("FAIL reset: got %b exp %b", obs, 7'b0); end
      end
      rst_n = 1'b1;
   endtask
   task automatic test_basic();
      set_cfg(20, 40, 40, 10, 10, 0, 20, 1, 0);
      start_seq();
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL basic cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
   endtask
   task automatic test_skip();
      set_cfg(20, 0, 40, 10, 0, 0, 20, 1, 0);
      start_seq();
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL skip cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
   endtask
   task automatic test_repeat();
      set_cfg(2, 0, 0, 0, 0, 0, 3, 3, 5);
      start_seq();
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL repeat cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
   endtask
   task automatic test_all_zero();
      set_cfg(0, 0, 0, 0, 0, 0, 0, 2, 0);
      start_seq();
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL allzero cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
   endtask
   task automatic test_abort();
      set_cfg(20, 40, 40, 10, 10, 0, 20, 1, 0);
      start_seq();
      repeat (31) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL abort_pre cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
      v = 1'b0;
      sb.delete();
      repeat (4) sb.push_back(7'b0000000);
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL abort_idle cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
      set_cfg(20, 0, 40, 10, 0, 0, 20, 1, 0);
      start_seq();
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL abort_restart cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
   endtask
   task automatic test_cfg_change();
      set_cfg(20, 40, 40, 10, 10, 0, 20, 1, 0);
      start_seq();
      repeat (41) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL cfgchg_pre cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
      pulse_len = {32'd7, 32'd5, 32'd3};
      rec_len = 32'd2; gap_len = '0; pulse_phase = '0;
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL cfgchg cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
   endtask
   task automatic test_async_reset();
      set_cfg(20, 40, 40, 10, 10, 0, 20, 1, 0);
      start_seq();
      repeat (131) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL areset_pre cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({adc, busy} !== 2'b00) begin errors++; $display("FAIL areset_async: adc/busy got %b exp 00", {adc, busy}); end
      v = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      repeat (5) sb.push_back(7'b0000000);
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL areset_post: got %b exp %b", obs, exp_v); end
      end
   endtask
   task automatic test_reset_start();
      set_cfg(3, 2, 1, 1, 0, 2, 2, 1, 0);
      rst_n = 1'b0;
      v = 1'b1;
      @(negedge clk);
      expand();
      rst_n = 1'b1;
      cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_v = sb.pop_front(); vectors++;
         if (obs !== exp_v) begin errors++; $display("FAIL reset_start cyc %0d: got %b exp %b", cyc, obs, exp_v); end
         cyc++;
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_skip();
      test_repeat();
      test_all_zero();
      test_abort();
      test_cfg_change();
      test_async_reset();
      test_reset_start();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/multi_pulse_sequencer.md
MULTI_PULSE_SEQUENCER -- requirements
Module: multi_pulse_sequencer

Interface
REQ-001 Parameter NUM_PULSES, default 4: number of RF pulse slots per shot.
REQ-002 Parameter TW, default 32: width of every timing field, in clk cycles.
REQ-003 Parameter PW, default 2: phase field width.
REQ-004 clk  in  1  single system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 RF_signal_valid  in  1  run enable; a rising edge starts a sequence, a low level aborts it.
REQ-007 pulse_len  in  NUM_PULSES*TW  pulse i length at [i*TW +: TW].
REQ-008 gap_len  in  NUM_PULSES*TW  delay after pulse i at [i*TW +: TW].
REQ-009 pulse_phase  in  NUM_PULSES*PW  pulse i phase at [i*PW +: PW].
REQ-010 rec_len  in  TW  receive window length.
REQ-011 rep_count  in  16  shots per sequence; 0 is treated as 1.
REQ-012 rep_delay  in  TW  dead time between shots.
REQ-013 TX_active_phase  out  PW  phase of the active pulse; 0 when no pulse is active.
REQ-014 amp_enable  out  1  high during pulse segments.
REQ-015 ADC_enable  out  1  high during the receive segment.
REQ-016 busy  out  1  high from LOAD through the last segment.
REQ-017 shot_done  out  1  one-cycle strobe at the end of each shot.
REQ-018 seq_done  out  1  one-cycle strobe at the end of the final shot.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, PULSE, GAP, REC and REPDLY, with one TW-bit down-counter, a pulse index and a 16-bit shot counter.
REQ-020 In IDLE, the first edge sampling RF_signal_valid=1 after it was sampled 0 SHALL enter LOAD; LOAD SHALL last 1 cycle and latch all config inputs.
REQ-021 Config input changes after LOAD SHALL have no effect until the next LOAD.
REQ-022 Shot order SHALL be PULSE0, GAP0, PULSE1, GAP1 ... PULSE(N-1), GAP(N-1), REC; a segment of length L SHALL last exactly L cycles.
REQ-023 Zero-length segments SHALL be skipped with no cycles consumed and no output glitch.
REQ-024 All outputs SHALL be registered and valid from the edge that enters their segment.
REQ-025 amp_enable SHALL equal (state==PULSE); TX_active_phase SHALL equal the latched phase of the current pulse in PULSE and 0 otherwise.
REQ-026 Adjacent pulses with a zero gap SHALL keep amp_enable continuously high while TX_active_phase switches at the boundary.
REQ-027 ADC_enable SHALL equal (state==REC).
REQ-028 At the end of a shot, shot_done SHALL pulse for 1 cycle; if shots remain, the FSM SHALL enter REPDLY for rep_delay cycles (busy high) and then restart at PULSE0.
REQ-029 After the last shot, the FSM SHALL enter IDLE, pulse shot_done and seq_done in the same cycle, and drop busy in that cycle.
REQ-030 If all segments and rep_delay are 0, each shot SHALL still take 1 cycle.
REQ-031 RF_signal_valid sampled 0 in any non-IDLE state SHALL move the FSM to IDLE on that edge, with all outputs 0 and no done strobes.
REQ-032 A restart after an abort SHALL require a new rising edge of RF_signal_valid and SHALL reload the config.
REQ-033 Holding RF_signal_valid high after seq_done SHALL NOT retrigger a sequence.

Reset
REQ-034 rst_n=0 SHALL immediately, without a clock edge, force IDLE and clear every output and counter to 0.
REQ-035 Reset release SHALL treat RF_signal_valid as previously 0, so a level already high starts on the first edge after release.

Verification
REQ-036 NUM_PULSES=3; len 20/40/40; gap 10/10/0; phase 1/2/3; rec 20; rep 1; start edge = LOAD at cycle 0 -> amp and phase 1 on cycles 1-20, gap 21-30, phase 2 on 31-70, gap 71-80, phase 3 on 81-120, ADC on 121-140, shot_done and seq_done at 141.
REQ-037 Same as REQ-036 but len1=0 and gap1=0 -> phase 1 on 1-20, gap 21-30, phase 3 on 31-70, ADC on 71-90.
REQ-038 len 2/0/0, gaps 0, rec 3, rep_count 3, rep_delay 5 -> three 5-cycle shots separated by 5 idle cycles with busy high, three shot_done strobes, one seq_done.
REQ-039 Drop RF_signal_valid at cycle 30 of REQ-036 -> all outputs 0 from the next edge, no done strobes; a new rising edge restarts with the changed config.
REQ-040 Assert rst_n=0 mid-REC -> ADC_enable and busy fall asynchronously; no strobes after release.
REQ-041 Change pulse_len during PULSE1 -> timing identical to REQ-036.
